alu_arbiter: RTL and testbench

//  Shares one ALU instance between NREQ requesters (e.g. execute stage, address-gen, debug unit).

---
 rtl/alu_pkg.sv | 24 ++
 rtl/alu.sv | 53 +++++
 rtl/rr_arbiter.sv | 57 +++++
 rtl/alu_arbiter.sv | 214 +++++++++++++++++++++
 tb/tb_alu_arbiter.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared ALU definitions used by the instruction decoder, the ALU itself and
// the ALU arbiter.
//   CTRL_W          : width of the ALU control code
//   ALU_ADD..SLTU   : ALU operation codes 0..9; codes 10..15 are undefined
//                     and make the ALU return res=0 / zero=1
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int CTRL_W = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1001;

endpackage : alu_pkg

// File: rtl/alu.sv
// ---------------------------------------------------------------------------
// alu
// Purely combinational integer ALU.
// Ports:
//   op1_i   [XLEN-1:0]   operand 1
//   op2_i   [XLEN-1:0]   operand 2 (low log2(XLEN) bits give the shift amount)
//   ctrl_i  [CTRL_W-1:0] operation code from alu_pkg
//   res_o   [XLEN-1:0]   result (0 for undefined codes)
//   zero_o               result == 0
// ---------------------------------------------------------------------------
module alu
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]   op1_i,
  input  logic [XLEN-1:0]   op2_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [XLEN-1:0]   res_o,
  output logic              zero_o
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_s;
  logic           slt_s;
  logic           sltu_s;

  assign shamt_s = op2_i[SHW-1:0];
  assign slt_s   = ($signed(op1_i) < $signed(op2_i));
  assign sltu_s  = (op1_i < op2_i);

  // Operation select; undefined codes fall through to a zero result.
  always_comb begin
    res_o = '0;
    case (ctrl_i)
      ALU_ADD:  res_o = op1_i + op2_i;
      ALU_SUB:  res_o = op1_i - op2_i;
      ALU_AND:  res_o = op1_i & op2_i;
      ALU_OR:   res_o = op1_i | op2_i;
      ALU_XOR:  res_o = op1_i ^ op2_i;
      ALU_SLL:  res_o = op1_i << shamt_s;
      ALU_SRL:  res_o = op1_i >> shamt_s;
      ALU_SRA:  res_o = $unsigned($signed(op1_i) >>> shamt_s);
      ALU_SLT:  res_o = {{(XLEN-1){1'b0}}, slt_s};
      ALU_SLTU: res_o = {{(XLEN-1){1'b0}}, sltu_s};
      default:  res_o = '0;
    endcase
  end

  assign zero_o = (res_o == '0);

endmodule : alu

// File: rtl/rr_arbiter.sv
// ---------------------------------------------------------------------------
// rr_arbiter
// Combinational one-hot arbiter over NREQ request lines.
// Build option: ALU_ARB_RR_EN
//   defined   : round-robin, search starts at ptr_i and wraps
//   undefined : fixed priority, lowest index wins; ptr_i port does not exist
// Ports:
//   req_i  [NREQ-1:0]  request vector
//   ptr_i  [PW-1:0]    round-robin start index (ALU_ARB_RR_EN only)
//   gnt_o  [NREQ-1:0]  one-hot grant, zero when no request is set
// ---------------------------------------------------------------------------
module rr_arbiter #(
  parameter int NREQ = 2,
  parameter int PW   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req_i,
`ifdef ALU_ARB_RR_EN
  input  logic [PW-1:0]   ptr_i,
`endif
  output logic [NREQ-1:0] gnt_o
);

  logic found_s;

`ifdef ALU_ARB_RR_EN
  logic hit_s;

  // Two passes: indices at/after the pointer first, then the wrapped-around
  // lower indices; the first set request in that order wins.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    hit_s   = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      hit_s    = req_i[i] & ~found_s & (PW'(i) >= ptr_i);
      gnt_o[i] = gnt_o[i] | hit_s;
      found_s  = found_s | hit_s;
    end
    for (int i = 0; i < NREQ; i++) begin
      hit_s    = req_i[i] & ~found_s & (PW'(i) < ptr_i);
      gnt_o[i] = gnt_o[i] | hit_s;
      found_s  = found_s | hit_s;
    end
  end
`else
  // Fixed priority: a request wins if no lower index is requesting.
  always_comb begin
    gnt_o   = '0;
    found_s = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      gnt_o[i] = req_i[i] & ~found_s;
      found_s  = found_s | req_i[i];
    end
  end
`endif

endmodule : rr_arbiter

// File: rtl/alu_arbiter.sv
// ---------------------------------------------------------------------------
// alu_arbiter
// Shares one ALU between NREQ requesters with valid/ready handshakes on both
// the request and the response side. One operation is in flight at a time.
// Build option: ALU_ARB_RR_EN selects round-robin arbitration (pointer moves
// to winner+1); without it the lowest requesting index always wins.
// Ports:
//   clk_i, reset_i           clock, synchronous active-high reset
//   req_valid_i/req_ready_o  per-requester request handshake (ready one-hot/0)
//   req_op1_i/req_op2_i      operands, requester i at [i*XLEN +: XLEN]
//   req_ctrl_i               ALU code, requester i at [i*CTRL_W +: CTRL_W]
//   rsp_valid_o/rsp_ready_i  per-requester response handshake (valid one-hot)
//   rsp_res_o/rsp_zero_o     shared registered result and zero flag
// Timing: a request whose handshake is visible in cycle c is executed in
// cycle c+1 and its response is valid from cycle c+2; when the response is
// accepted the next request can be taken in the same cycle (1 op / 2 cycles).
// ---------------------------------------------------------------------------
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREQ = 2
) (
  input  logic                   clk_i,
  input  logic                   reset_i,
  input  logic [NREQ-1:0]        req_valid_i,
  output logic [NREQ-1:0]        req_ready_o,
  input  logic [NREQ*XLEN-1:0]   req_op1_i,
  input  logic [NREQ*XLEN-1:0]   req_op2_i,
  input  logic [NREQ*CTRL_W-1:0] req_ctrl_i,
  output logic [NREQ-1:0]        rsp_valid_o,
  input  logic [NREQ-1:0]        rsp_ready_i,
  output logic [XLEN-1:0]        rsp_res_o,
  output logic                   rsp_zero_o
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_RESP = 2'b10;

  logic [1:0]        state_q,     state_d;
  logic [XLEN-1:0]   op1_q,       op1_d;
  logic [XLEN-1:0]   op2_q,       op2_d;
  logic [CTRL_W-1:0] ctrl_q,      ctrl_d;
  logic [PW-1:0]     owner_q,     owner_d;
  logic [XLEN-1:0]   res_q,       res_d;
  logic              zero_q,      zero_d;
  logic [NREQ-1:0]   rsp_valid_q, rsp_valid_d;

  logic [NREQ-1:0]   gnt_s;
  logic [PW-1:0]     win_idx_s;
  logic [XLEN-1:0]   op1_sel_s;
  logic [XLEN-1:0]   op2_sel_s;
  logic [CTRL_W-1:0] ctrl_sel_s;
  logic [XLEN-1:0]   alu_res_s;
  logic              alu_zero_s;
  logic              rsp_accept_s;
  logic              slot_free_s;
  logic              req_fire_s;
  logic [NREQ-1:0]   owner_onehot_s;

  // -------------------------------------------------------------------------
  // Arbitration
  // -------------------------------------------------------------------------
`ifdef ALU_ARB_RR_EN
  logic [PW-1:0] ptr_q, ptr_d;

  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (gnt_s)
  );
`else
  rr_arbiter #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_arbiter (
    .req_i (req_valid_i),
    .gnt_o (gnt_s)
  );
`endif

  // Only the owner's rsp_ready counts; other requesters cannot retire it.
  assign rsp_accept_s = (state_q == ST_RESP) & rsp_ready_i[owner_q];
  assign slot_free_s  = (state_q == ST_IDLE) | rsp_accept_s;
  assign req_ready_o  = slot_free_s ? gnt_s : '0;
  // The grant only covers valid requesters, so any ready bit is a transfer.
  assign req_fire_s   = |req_ready_o;

  assign owner_onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

  // One-hot AND-OR mux of the winning requester's fields and index.
  always_comb begin
    win_idx_s  = '0;
    op1_sel_s  = '0;
    op2_sel_s  = '0;
    ctrl_sel_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      win_idx_s  = win_idx_s  | (PW'(i) & {PW{gnt_s[i]}});
      op1_sel_s  = op1_sel_s  | (req_op1_i[i*XLEN +: XLEN] & {XLEN{gnt_s[i]}});
      op2_sel_s  = op2_sel_s  | (req_op2_i[i*XLEN +: XLEN] & {XLEN{gnt_s[i]}});
      ctrl_sel_s = ctrl_sel_s | (req_ctrl_i[i*CTRL_W +: CTRL_W] & {CTRL_W{gnt_s[i]}});
    end
  end

  // -------------------------------------------------------------------------
  // Shared ALU, fed only from the registered operands
  // -------------------------------------------------------------------------
  alu #(
    .XLEN (XLEN)
  ) u_alu (
    .op1_i  (op1_q),
    .op2_i  (op2_q),
    .ctrl_i (ctrl_q),
    .res_o  (alu_res_s),
    .zero_o (alu_zero_s)
  );

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // Operand capture on request transfer, plus the IDLE/EXEC/RESP sequencing.
  always_comb begin
    op1_d   = req_fire_s ? op1_sel_s  : op1_q;
    op2_d   = req_fire_s ? op2_sel_s  : op2_q;
    ctrl_d  = req_fire_s ? ctrl_sel_s : ctrl_q;
    owner_d = req_fire_s ? win_idx_s  : owner_q;

    state_d     = state_q;
    res_d       = res_q;
    zero_d      = zero_q;
    rsp_valid_d = rsp_valid_q;

    case (state_q)
      ST_IDLE: begin
        state_d = req_fire_s ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        state_d     = ST_RESP;
        res_d       = alu_res_s;
        zero_d      = alu_zero_s;
        rsp_valid_d = owner_onehot_s;
      end
      ST_RESP: begin
        if (rsp_accept_s) begin
          rsp_valid_d = '0;
          state_d     = req_fire_s ? ST_EXEC : ST_IDLE;
        end else begin
          state_d     = ST_RESP;
        end
      end
      default: begin
        state_d     = ST_IDLE;
        rsp_valid_d = '0;
      end
    endcase
  end

`ifdef ALU_ARB_RR_EN
  // Pointer moves just past the winner so it gets lowest priority next time.
  always_comb begin
    if (req_fire_s) begin
      ptr_d = (win_idx_s == PW'(NREQ - 1)) ? '0 : (win_idx_s + PW'(1));
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // State registers; reset drops any in-flight operation.
  // -------------------------------------------------------------------------
  // FSM, operand, owner and response registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_IDLE;
      op1_q       <= '0;
      op2_q       <= '0;
      ctrl_q      <= '0;
      owner_q     <= '0;
      res_q       <= '0;
      zero_q      <= 1'b0;
      rsp_valid_q <= '0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      ctrl_q      <= ctrl_d;
      owner_q     <= owner_d;
      res_q       <= res_d;
      zero_q      <= zero_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  assign rsp_valid_o = rsp_valid_q;
  assign rsp_res_o   = res_q;
  assign rsp_zero_o  = zero_q;

endmodule : alu_arbiter

// File: tb/tb_alu_arbiter.sv
// ---------------------------------------------------------------------------
// tb_alu_arbiter
// Directed self-checking bench for alu_arbiter (XLEN=32, NREQ=2).
// Inputs change 1 time unit after the rising edge; outputs are checked
// after the inputs have settled, well away from the next rising edge.
// ---------------------------------------------------------------------------
module tb_alu_arbiter;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam int NREQ = 2;

  logic                   clk;
  logic                   reset;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*XLEN-1:0]   req_op1;
  logic [NREQ*XLEN-1:0]   req_op2;
  logic [NREQ*CTRL_W-1:0] req_ctrl;
  logic [NREQ-1:0]        rsp_valid;
  logic [NREQ-1:0]        rsp_ready;
  logic [XLEN-1:0]        rsp_res;
  logic                   rsp_zero;

  int checks;
  int failures;

  alu_arbiter #(
    .XLEN (XLEN),
    .NREQ (NREQ)
  ) dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_op1_i   (req_op1),
    .req_op2_i   (req_op2),
    .req_ctrl_i  (req_ctrl),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_res_o   (rsp_res),
    .rsp_zero_o  (rsp_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] c);
    req_op1[i*XLEN +: XLEN]     = a;
    req_op2[i*XLEN +: XLEN]     = b;
    req_ctrl[i*CTRL_W +: CTRL_W] = c;
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    step(); step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; req_valid = '0; rsp_ready = '0;
    req_op1 = '0; req_op2 = '0; req_ctrl = '0;
    step(); step(); step();
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_res !== 32'h0) begin failures++; $display("FAIL reset_rsp_res got=%h exp=0", rsp_res); end
    checks++; if (rsp_zero !== 1'b0) begin failures++; $display("FAIL reset_rsp_zero got=%b exp=0", rsp_zero); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL reset_req_ready got=%b exp=00", req_ready); end
    reset = 1'b0;
    step();
  endtask

  task automatic test_single();
    set_req(0, 32'd5, 32'd7, ALU_ADD);
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL single_ready got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_exec_valid got=%b exp=00", rsp_valid); end
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL single_exec_ready got=%b exp=00", req_ready); end
    step();
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL single_rsp_valid got=%b exp=01", rsp_valid); end
    checks++; if (rsp_res !== 32'd12) begin failures++; $display("FAIL single_res got=%h exp=0000000c", rsp_res); end
    checks++; if (rsp_zero !== 1'b0) begin failures++; $display("FAIL single_zero got=%b exp=0", rsp_zero); end
    rsp_ready = 2'b01;
    step();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL single_retire got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_two();
    do_reset();
    set_req(0, 32'd3, 32'd3, ALU_SUB);
    set_req(1, 32'd1, 32'd2, ALU_SLTU);
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL two_first_grant got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL two_exec_ready got=%b exp=00", req_ready); end
    step();
    checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL two_rsp0_valid got=%b exp=01", rsp_valid); end
    checks++; if (rsp_res !== 32'd0) begin failures++; $display("FAIL two_rsp0_res got=%h exp=0", rsp_res); end
    checks++; if (rsp_zero !== 1'b1) begin failures++; $display("FAIL two_rsp0_zero got=%b exp=1", rsp_zero); end
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL two_second_grant got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL two_exec2_valid got=%b exp=00", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL two_rsp1_valid got=%b exp=10", rsp_valid); end
    checks++; if (rsp_res !== 32'd1) begin failures++; $display("FAIL two_rsp1_res got=%h exp=1", rsp_res); end
    checks++; if (rsp_zero !== 1'b0) begin failures++; $display("FAIL two_rsp1_zero got=%b exp=0", rsp_zero); end
    step();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL two_retire got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_priority();
    logic [1:0] exp_g [3];
`ifdef ALU_ARB_RR_EN
    exp_g = '{2'b01, 2'b10, 2'b01};
`else
    exp_g = '{2'b01, 2'b01, 2'b01};
`endif
    do_reset();
    set_req(0, 32'd9, 32'd4, ALU_SUB);
    set_req(1, 32'd6, 32'd6, ALU_XOR);
    req_valid = 2'b11; rsp_ready = 2'b11;
    #1;
    for (int k = 0; k < 6; k++) begin
      if (k % 2 == 0) begin
        checks++; if (req_ready !== exp_g[k/2]) begin failures++; $display("FAIL prio_grant%0d got=%b exp=%b", k/2, req_ready, exp_g[k/2]); end
      end else begin
        checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL prio_exec%0d got=%b exp=00", k/2, req_ready); end
      end
      step();
    end
    req_valid = 2'b00;
    step();
    rsp_ready = 2'b00;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL prio_drain got=%b exp=00", rsp_valid); end
  endtask

  task automatic test_backpressure();
    set_req(0, 32'd10, 32'd20, ALU_ADD);
    set_req(1, 32'h0F, 32'hFF, ALU_XOR);
    req_valid = 2'b01; rsp_ready = 2'b00;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL bp_grant0 got=%b exp=01", req_ready); end
    step();
    req_valid = 2'b10;
    step();
    for (int k = 0; k < 3; k++) begin
      rsp_ready = (k == 1) ? 2'b10 : 2'b00;
      #1;
      checks++; if (rsp_valid !== 2'b01) begin failures++; $display("FAIL bp_hold_valid%0d got=%b exp=01", k, rsp_valid); end
      checks++; if (rsp_res !== 32'd30) begin failures++; $display("FAIL bp_hold_res%0d got=%h exp=0000001e", k, rsp_res); end
      checks++; if (req_ready !== 2'b00) begin failures++; $display("FAIL bp_hold_ready%0d got=%b exp=00", k, req_ready); end
      step();
    end
    rsp_ready = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b10) begin failures++; $display("FAIL bp_same_cycle_grant got=%b exp=10", req_ready); end
    step();
    req_valid = 2'b00; rsp_ready = 2'b00;
    #1;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL bp_exec1_valid got=%b exp=00", rsp_valid); end
    step();
    checks++; if (rsp_valid !== 2'b10) begin failures++; $display("FAIL bp_rsp1_valid got=%b exp=10", rsp_valid); end
    checks++; if (rsp_res !== 32'h000000F0) begin failures++; $display("FAIL bp_rsp1_res got=%h exp=000000f0", rsp_res); end
    rsp_ready = 2'b10;
    step();
    rsp_ready = 2'b00;
  endtask

  task automatic test_reset_exec();
    set_req(0, 32'd1, 32'd1, ALU_ADD);
    req_valid = 2'b01; rsp_ready = 2'b01;
    step();
    req_valid = 2'b00;
    reset = 1'b1;
    step();
    reset = 1'b0;
    checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rstx_valid got=%b exp=00", rsp_valid); end
    checks++; if (rsp_res !== 32'd0) begin failures++; $display("FAIL rstx_res got=%h exp=0", rsp_res); end
    checks++; if (rsp_zero !== 1'b0) begin failures++; $display("FAIL rstx_zero got=%b exp=0", rsp_zero); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin failures++; $display("FAIL rstx_idle_grant got=%b exp=01", req_ready); end
    req_valid = 2'b00;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (rsp_valid !== 2'b00) begin failures++; $display("FAIL rstx_stale%0d got=%b exp=00", k, rsp_valid); end
    end
    rsp_ready = 2'b00;
  endtask

  task automatic test_alu_ops();
    logic [31:0] va [13];
    logic [31:0] vb [13];
    logic [3:0]  vc [13];
    logic [31:0] vr [13];
    logic        vz [13];
    int          n;
    va = '{32'd5, 32'hF0F0F0F0, 32'h0F000000, 32'hAAAAAAAA, 32'd1, 32'h80000000,
           32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd5, 32'hFFFFFFFF, 32'd6};
    vb = '{32'd7, 32'hFF00FF00, 32'h000000F0, 32'hAAAAAAAA, 32'd31, 32'd4,
           32'h00000024, 32'd2, 32'd2, 32'd1, 32'd7, 32'd1, 32'd5};
    vc = '{ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL,
           ALU_SRA, ALU_SLT, ALU_SLTU, 4'b1010, 4'b1111, ALU_ADD, ALU_SLT};
    vr = '{32'hFFFFFFFE, 32'hF000F000, 32'h0F0000F0, 32'h0, 32'h80000000, 32'h08000000,
           32'hF8000000, 32'd1, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    vz = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int v = 0; v < 13; v++) begin
      set_req(1, va[v], vb[v], vc[v]);
      req_valid = 2'b10; rsp_ready = 2'b00;
      step();
      req_valid = 2'b00;
      n = 0;
      while (rsp_valid !== 2'b10 && n < 6) begin
        step();
        n++;
      end
      checks++; if (n !== 1) begin failures++; $display("FAIL op%0d_latency got=%0d exp=1", v, n); end
      checks++; if (rsp_res !== vr[v]) begin failures++; $display("FAIL op%0d_res got=%h exp=%h", v, rsp_res, vr[v]); end
      checks++; if (rsp_zero !== vz[v]) begin failures++; $display("FAIL op%0d_zero got=%b exp=%b", v, rsp_zero, vz[v]); end
      rsp_ready = 2'b10;
      step();
      rsp_ready = 2'b00;
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    reset = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    req_op1 = '0;
    req_op2 = '0;
    req_ctrl = '0;
    test_reset();
    test_single();
    test_two();
    test_priority();
    test_backpressure();
    test_reset_exec();
    test_alu_ops();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_alu_arbiter
